// File: rtl/combo_lock_fsm_pkg.sv
// ============================================================================
//  Module   : combo_lock_fsm_pkg
//  Purpose  : Shared state encodings, led status words and code helpers for
//             the combination-lock controller, its display and its bench.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package combo_lock_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_t;

    localparam logic [3:0] c_led_idle    = 4'b0001;
    localparam logic [3:0] c_led_entry   = 4'b0010;
    localparam logic [3:0] c_led_open    = 4'b0100;
    localparam logic [3:0] c_led_lockout = 4'b1000;
    localparam logic [3:0] c_led_fail    = 4'b0000;

    // Digit idx of a code packed two bits per digit, digit 0 in the LSBs.
    function automatic logic [1:0] code_digit(input logic [15:0] code,
                                              input logic [2:0]  idx);
        return code[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [3:0] led_of(input lock_state_t state);
        case (state)
            ST_IDLE:    return c_led_idle;
            ST_ENTRY:   return c_led_entry;
            ST_OPEN:    return c_led_open;
            ST_LOCKOUT: return c_led_lockout;
            default:    return c_led_fail;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/combo_lock_fsm_timer.sv
// ============================================================================
//  Module   : lock_timer
//  Purpose  : Saturating up-counter with synchronous clear and a
//             terminal-count compare against a caller-supplied target.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] target,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (r_count != {WIDTH{1'b1}}) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign done = (r_count == target);

endmodule

`default_nettype wire

// File: rtl/combo_lock_fsm.sv
// ============================================================================
//  Module   : combo_lock_fsm
//  Purpose  : Combination-lock controller: digit entry with timeout, code
//             check, timed open, failed-attempt counting and timed lockout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module combo_lock_fsm
    import combo_lock_fsm_pkg::*;
#(
    parameter int                    CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0] CODE           = 8'hE4,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 250_000_000,
    parameter int                    ENTRY_TIMEOUT  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_pulse,
    output logic [3:0] led,
    output logic       unlocked,
    output logic       locked_out,
    output logic [2:0] digit_cnt
);

    localparam int c_tmax_ul = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int c_tmax    = (c_tmax_ul > ENTRY_TIMEOUT) ? c_tmax_ul : ENTRY_TIMEOUT;
    localparam int TW        = $clog2(c_tmax + 1);
    localparam int FW        = $clog2(MAX_TRIES + 1);

    localparam logic [15:0]   c_code_ext  = 16'(CODE);
    localparam logic [2:0]    c_last_idx  = 3'(CODE_LEN - 1);
    localparam logic [FW-1:0] c_max_tries = FW'(MAX_TRIES);

    lock_state_t   r_state, w_state_next;
    logic [2:0]    r_digit_cnt, w_digit_cnt_next;
    logic          r_mismatch, w_mismatch_next;
    logic [FW-1:0] r_fail_cnt, w_fail_cnt_next;
    logic [FW-1:0] w_fail_inc;

    logic          w_press;
    logic          w_digit_bad;
    logic          w_last_digit;
    logic          w_timer_clr;
    logic          w_timer_done;
    logic [TW-1:0] w_timer_target;

    assign w_press      = |btn_pulse;
    // Multi-bit presses never equal a one-hot pattern, so they always mismatch.
    assign w_digit_bad  = (btn_pulse != (4'b0001 << code_digit(c_code_ext, r_digit_cnt)));
    assign w_last_digit = (r_digit_cnt == c_last_idx);
    assign w_fail_inc   = r_fail_cnt + FW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_digit_cnt <= w_digit_cnt_next;
            r_mismatch  <= w_mismatch_next;
            r_fail_cnt  <= w_fail_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_digit_cnt_next = r_digit_cnt;
        w_mismatch_next  = r_mismatch;
        w_fail_cnt_next  = r_fail_cnt;
        case (r_state)
            // IDLE shares the digit path: digit_cnt and mismatch are both zero there.
            ST_IDLE, ST_ENTRY: begin
                if (w_press) begin
                    if (w_last_digit) begin
                        w_digit_cnt_next = '0;
                        w_mismatch_next  = 1'b0;
                        if (r_mismatch || w_digit_bad) begin
                            w_state_next = ST_FAIL;
                        end else begin
                            w_state_next    = ST_OPEN;
                            w_fail_cnt_next = '0;
                        end
                    end else begin
                        w_state_next     = ST_ENTRY;
                        w_digit_cnt_next = r_digit_cnt + 3'd1;
                        w_mismatch_next  = r_mismatch | w_digit_bad;
                    end
                end else if (r_state == ST_ENTRY && w_timer_done) begin
                    w_state_next     = ST_IDLE;
                    w_digit_cnt_next = '0;
                    w_mismatch_next  = 1'b0;
                end
            end
            ST_OPEN: begin
                if (w_timer_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (w_fail_inc == c_max_tries) begin
                    w_state_next    = ST_LOCKOUT;
                    w_fail_cnt_next = '0;
                end else begin
                    w_state_next    = ST_IDLE;
                    w_fail_cnt_next = w_fail_inc;
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_digit_cnt_next = '0;
                w_mismatch_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_timer_target = {TW{1'b1}};
        case (r_state)
            ST_ENTRY:   w_timer_target = TW'(ENTRY_TIMEOUT - 1);
            ST_OPEN:    w_timer_target = TW'(UNLOCK_CYCLES - 1);
            ST_LOCKOUT: w_timer_target = TW'(LOCKOUT_CYCLES - 1);
            default:    w_timer_target = {TW{1'b1}};
        endcase
    end

    // Timer restarts on every state change and on each accepted digit.
    assign w_timer_clr = (w_state_next != r_state) || (r_state == ST_ENTRY && w_press);

    lock_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_timer_clr),
        .target (w_timer_target),
        .done   (w_timer_done)
    );

    assign led        = led_of(r_state);
    assign unlocked   = (r_state == ST_OPEN);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign digit_cnt  = r_digit_cnt;

endmodule

`default_nettype wire
